// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int ALIGN_BITS = 2;

    // Index width for a word array; never less than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: synchronous byte-enabled write and
// combinational read on a single shared word address. Contents are never
// cleared by reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int DATA_W      = 32,
    parameter int AW          = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    // Byte-lane write at the clock edge; lanes with a clear enable keep their value.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: one outstanding word
// load/store, response pulse LATENCY cycles after acceptance.
// Optional feature: define DMEM_BYTE_STROBE_EN to add req_be[3:0] byte
// strobes for stores (req_be==0 on a store is reported as an error).
// DATA_W is fixed at 32; other values are not supported.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | nothing outstanding, ready for a request
//   WAIT  | request accepted, cnt counts down to the response cycle
//   RESP  | rsp_valid pulse from the holding registers; may accept again
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]        req_be,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int         AW       = idx_width(DEPTH_WORDS);
    localparam int         WA_W     = 32 - ALIGN_BITS;
    // Loaded on accept so that cnt==0 in WAIT marks the last wait cycle.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_rdata_q, hold_rdata_d;
    logic              hold_err_q, hold_err_d;

    logic              accept;
    logic [WA_W-1:0]   word_addr;
    logic [AW-1:0]     word_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              be_err;
    logic              req_err;
    logic [3:0]        wr_be;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    assign accept       = req_valid & req_ready;
    assign word_addr    = req_addr[31:ALIGN_BITS];
    assign word_idx     = word_addr[AW-1:0];
    assign misaligned   = |req_addr[ALIGN_BITS-1:0];
    assign out_of_range = (word_addr >= WA_W'(DEPTH_WORDS));

`ifdef DMEM_BYTE_STROBE_EN
    // A store with no lanes enabled would silently do nothing; flag it instead.
    assign be_err = req_we & (req_be == 4'd0);
    assign wr_be  = req_be;
`else
    assign be_err = 1'b0;
    assign wr_be  = 4'hF;
`endif

    assign req_err = misaligned | out_of_range | be_err;

    // Stores commit at their accept edge, so a later load always sees them.
    assign arr_we = accept & req_we & ~req_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (wr_be),
        .addr  (word_idx),
        .wdata (req_wdata),
        .rdata (arr_rdata)
    );

    // State, wait counter and response holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            hold_rdata_q <= '0;
            hold_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_rdata_q <= hold_rdata_d;
            hold_err_q   <= hold_err_d;
        end
    end

    // Next state; an accept (only possible in IDLE or RESP) overrides the step.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_rdata_d = hold_rdata_q;
        hold_err_d   = hold_err_q;

        case (state_q)
            IDLE: state_d = IDLE;
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (LATENCY == 1) begin
                state_d = RESP;
            end else begin
                state_d = WAIT;
            end
            cnt_d        = CNT_INIT;
            hold_err_d   = req_err;
            hold_rdata_d = (req_we | req_err) ? '0 : arr_rdata;
        end
    end

    assign req_ready = (state_q == IDLE) | (state_q == RESP);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? hold_rdata_q : '0;
    assign rsp_err   = rsp_valid & hold_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with LATENCY 2, 1 and 4.
module tb_dmem_responder;

    localparam int N = 3;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        req_valid [N];
    logic        req_we    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  req_be    [N];
`endif
    wire         req_ready [N];
    wire         rsp_valid [N];
    wire  [31:0] rsp_rdata [N];
    wire         rsp_err   [N];
    wire         busy      [N];

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (64),
            .LATENCY     (g == 0 ? 2 : (g == 1 ? 1 : 4)),
            .DATA_W      (32)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
`ifdef DMEM_BYTE_STROBE_EN
            .req_be    (req_be[g]),
`endif
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation of its instance.
    always @(negedge clk) begin
        int idx;
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] === 1'b1) begin
                idx = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (idx < 0 && sb[j].inst == i) idx = j;
                end
                n_vec++;
                if (idx < 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rsp inst%0d: rdata %h err %b with nothing pending", i, rsp_rdata[i], rsp_err[i]);
                end else begin
                    if (rsp_rdata[i] !== sb[idx].rdata || rsp_err[i] !== sb[idx].err || cyc != sb[idx].cyc) begin
                        n_bad++;
                        $display("FAIL rsp inst%0d: got rdata %h err %b cyc %0d, expected rdata %h err %b cyc %0d",
                                 i, rsp_rdata[i], rsp_err[i], cyc, sb[idx].rdata, sb[idx].err, sb[idx].cyc);
                    end
                    sb.delete(idx);
                end
            end else if (rst[i] === 1'b0) begin
                n_vec++;
                if (rsp_rdata[i] !== 32'd0 || rsp_err[i] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_outputs inst%0d: rdata %h err %b expected 0 0", i, rsp_rdata[i], rsp_err[i]);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accept edge with valid dropped.
    task automatic issue(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] erd, input logic eerr, input bit expect_rsp);
        int budget;
        budget       = 0;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
`ifdef DMEM_BYTE_STROBE_EN
        req_be[i]    = be;
`endif
        while (req_ready[i] !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (req_ready[i] !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout inst%0d: req_ready %b expected 1 (be %h)", i, req_ready[i], be);
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        if (expect_rsp) sb.push_back('{i, erd, eerr, cyc + lat_of(i) - 1});
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses missing, expected 0", sb.size());
            sb.delete();
        end
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected under 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i]       = 1'b1;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
            req_be[i]    = 4'hF;
`endif
        end
        tick(3);
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("reset_busy",      32'(busy[i]),      32'd0);
            chk("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("reset_rsp_rdata", rsp_rdata[i],      32'd0);
            chk("reset_rsp_err",   32'(rsp_err[i]),   32'd0);
            chk("reset_req_ready", 32'(req_ready[i]), 32'd1);
        end
        tick(1);

        // LATENCY=2: store then load of the same word
        issue(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 1);
        chk("busy_after_accept", 32'(busy[0]), 32'd1);
        issue(0, 1'b0, 32'h8, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0, 1);
        drain();

        // Misaligned accesses
        issue(0, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, 32'd0, 1'b0, 1);
        issue(0, 1'b0, 32'h6, 32'd0, 4'hF, 32'd0, 1'b1, 1);
        issue(0, 1'b1, 32'h7, 32'h55, 4'hF, 32'd0, 1'b1, 1);
        issue(0, 1'b0, 32'h4, 32'd0, 4'hF, 32'h0BADF00D, 1'b0, 1);
        drain();

        // Out of range store leaves every word untouched
        for (int w = 0; w < 64; w++)
            issue(0, 1'b1, 32'(w * 4), 32'hA5000000 | 32'(w), 4'hF, 32'd0, 1'b0, 1);
        issue(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, 1);
        issue(0, 1'b0, 32'h100, 32'd0, 4'hF, 32'd0, 1'b1, 1);
        for (int w = 0; w < 64; w++)
            issue(0, 1'b0, 32'(w * 4), 32'd0, 4'hF, 32'hA5000000 | 32'(w), 1'b0, 1);
        issue(0, 1'b0, 32'h0000_00FC, 32'd0, 4'hF, 32'hA500003F, 1'b0, 1);
        drain();

`ifdef DMEM_BYTE_STROBE_EN
        issue(0, 1'b1, 32'h0, 32'h11223344, 4'hF,     32'd0, 1'b0, 1);
        issue(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101,  32'd0, 1'b0, 1);
        issue(0, 1'b0, 32'h0, 32'd0,        4'b0000,  32'h11BB33DD, 1'b0, 1);
        issue(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000,  32'd0, 1'b1, 1);
        issue(0, 1'b0, 32'h0, 32'd0,        4'hF,     32'h11BB33DD, 1'b0, 1);
        drain();
`endif

        // LATENCY=1: back-to-back stores, then back-to-back loads
        for (int w = 0; w < 4; w++)
            issue(1, 1'b1, 32'(w * 4), 32'h11110000 + 32'(w), 4'hF, 32'd0, 1'b0, 1);
        for (int w = 0; w < 4; w++) begin
            chk("b2b_ready", 32'(req_ready[1]), 32'd1);
            issue(1, 1'b0, 32'(w * 4), 32'd0, 4'hF, 32'h11110000 + 32'(w), 1'b0, 1);
        end
        issue(1, 1'b1, 32'h10, 32'h00000077, 4'hF, 32'd0, 1'b0, 1);
        issue(1, 1'b0, 32'h10, 32'd0, 4'hF, 32'h00000077, 1'b0, 1);
        issue(1, 1'b0, 32'h3, 32'd0, 4'hF, 32'd0, 1'b1, 1);
        drain();

        // LATENCY=4: plain load timing, then reset during outstanding transactions
        issue(2, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'd0, 1'b0, 1);
        issue(2, 1'b0, 32'h20, 32'd0, 4'hF, 32'h12345678, 1'b0, 1);
        drain();

        issue(2, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0, 0);
        tick(2);
        rst[2] = 1'b1;
        #1;
        chk("reset_mid_wait_busy",  32'(busy[2]),      32'd0);
        chk("reset_mid_wait_valid", 32'(rsp_valid[2]), 32'd0);
        tick(1);
        rst[2] = 1'b0;
        tick(6);
        chk("post_reset_busy",  32'(busy[2]),      32'd0);
        chk("post_reset_ready", 32'(req_ready[2]), 32'd1);
        issue(2, 1'b0, 32'h24, 32'd0, 4'hF, 32'hCAFEF00D, 1'b0, 1);
        drain();

        issue(2, 1'b0, 32'h20, 32'd0, 4'hF, 32'd0, 1'b0, 0);
        tick(2);
        rst[2] = 1'b1;
        tick(1);
        rst[2] = 1'b0;
        tick(6);
        chk("load_drop_busy", 32'(busy[2]), 32'd0);
        issue(2, 1'b0, 32'h20, 32'd0, 4'hF, 32'h12345678, 1'b0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
